// File: rtl/bridge_pkg.sv
// Shared definitions for the 16-to-32 bit access bridge: FSM encoding and lane helpers.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        HIT   = 2'b01,
        TGT   = 2'b11,
        COMPL = 2'b10
    } state_t;

    function automatic logic [15:0] hword_sel(input logic [31:0] word, input logic hi);
        return hi ? word[31:16] : word[15:0];
    endfunction

    function automatic logic [3:0] lane_be(input logic [1:0] bsel, input logic hi);
        return hi ? {bsel, 2'b00} : {2'b00, bsel};
    endfunction

endpackage

// File: rtl/bridge_16_32_hword_buf.sv
// One-word read buffer: tag compare, fill, byte-merge on matching writes, invalidate.
module hword_buf (
    input  logic        clk,
    input  logic        rst,
    input  logic        inv,
    input  logic [29:0] lookup_tag,
    output logic        hit,
    output logic [31:0] data,
    input  logic [29:0] wtag,
    input  logic        fill,
    input  logic [31:0] fill_data,
    input  logic        merge,
    input  logic [3:0]  merge_be,
    input  logic [31:0] merge_data
);

    logic        valid;
    logic [29:0] tag;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            tag   <= '0;
            data  <= '0;
        end else begin
            if (fill) begin
                data <= fill_data;
                tag  <= wtag;
            end else if (merge && valid && (tag == wtag)) begin
                for (int i = 0; i < 4; i++) begin
                    if (merge_be[i]) data[i*8 +: 8] <= merge_data[i*8 +: 8];
                end
            end
            // A fill coinciding with inv still loads data but leaves the entry invalid.
            if (inv)       valid <= 1'b0;
            else if (fill) valid <= 1'b1;
        end
    end

    assign hit = valid && (tag == lookup_tag);

endmodule

// File: rtl/bridge_16_32.sv
// Halfword initiator to 32-bit target bridge with a one-word read buffer.
// state | meaning: IDLE wait for request | HIT serve from buffer | TGT target access | COMPL host completion
module bridge_16_32 #(
    parameter bit BUF_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] h_addr,
    input  logic [15:0] h_wdata,
    output logic [15:0] h_rdata,
    input  logic        h_wr_en,
    input  logic [1:0]  h_bytesel,
    output logic        h_compl,
    input  logic        inv,
    output logic [31:0] t_addr,
    output logic [31:0] t_wdata,
    input  logic [31:0] t_rdata,
    output logic        t_wr_en,
    output logic [3:0]  t_bytesel,
    input  logic        t_compl
);
    import bridge_pkg::*;

    state_t      state, state_nxt;
    logic        buf_hit;
    logic [31:0] buf_data;
    logic        hit_dec;
    logic        tgt_done;

    logic [15:0] h_rdata_d;
    logic        h_compl_d;
    logic [31:0] t_addr_d;
    logic [31:0] t_wdata_d;
    logic        t_wr_en_d;
    logic [3:0]  t_bytesel_d;

    assign hit_dec  = BUF_EN && buf_hit && !inv && !h_wr_en;
    assign tgt_done = (state == TGT) && t_compl;

    hword_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .inv        (inv),
        .lookup_tag (h_addr[31:2]),
        .hit        (buf_hit),
        .data       (buf_data),
        .wtag       (t_addr[31:2]),
        .fill       (tgt_done && !t_wr_en && BUF_EN),
        .fill_data  (t_rdata),
        .merge      (tgt_done && t_wr_en),
        .merge_be   (t_bytesel),
        .merge_data (t_wdata)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (h_bytesel != 2'b00) state_nxt = hit_dec ? HIT : TGT;
            HIT:     state_nxt = IDLE;
            TGT:     if (t_compl) state_nxt = COMPL;
            COMPL:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Next values of the registered host/target outputs.
    always_comb begin
        h_compl_d   = 1'b0;
        h_rdata_d   = h_rdata;
        t_addr_d    = t_addr;
        t_wdata_d   = t_wdata;
        t_wr_en_d   = t_wr_en;
        t_bytesel_d = t_bytesel;
        case (state)
            IDLE: begin
                if (h_bytesel != 2'b00) begin
                    if (hit_dec) begin
                        h_compl_d = 1'b1;
                        h_rdata_d = hword_sel(buf_data, h_addr[1]);
                    end else begin
                        t_addr_d    = {h_addr[31:2], h_addr[1:0] & 2'b00};
                        t_wdata_d   = {h_wdata, h_wdata};
                        t_wr_en_d   = h_wr_en;
                        t_bytesel_d = h_wr_en ? lane_be(h_bytesel, h_addr[1]) : 4'hF;
                    end
                end
            end
            TGT: begin
                if (t_compl) begin
                    h_compl_d   = 1'b1;
                    t_bytesel_d = 4'h0;
                    t_wr_en_d   = 1'b0;
                    if (!t_wr_en) h_rdata_d = hword_sel(t_rdata, h_addr[1]);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            h_compl   <= 1'b0;
            h_rdata   <= '0;
            t_addr    <= '0;
            t_wdata   <= '0;
            t_wr_en   <= 1'b0;
            t_bytesel <= '0;
        end else begin
            h_compl   <= h_compl_d;
            h_rdata   <= h_rdata_d;
            t_addr    <= t_addr_d;
            t_wdata   <= t_wdata_d;
            t_wr_en   <= t_wr_en_d;
            t_bytesel <= t_bytesel_d;
        end
    end

endmodule

// File: doc/bridge_16_32.md
# bridge_16_32

Converts 16-bit halfword read/write accesses into single 32-bit accesses on a 32-bit target bus. It sits between a 16-bit initiator (debug port, DMA or narrow peripheral master) and the 32-bit memory/SDRAM path. A one-word read buffer lets the second halfword of a word be served without a new target access. Writes go straight through to the target and update the buffer when it holds the same word.

## Interface
Parameters:
- BUF_EN, 1, enables the read buffer; 0 makes every read a target access.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-high
- h_addr  in  32  halfword byte address; bit 0 ignored
- h_wdata  in  16  write data
- h_rdata  out  16  read data; valid from the h_compl cycle until the next read completion
- h_wr_en  in  1  1 = write, 0 = read
- h_bytesel  in  2  byte enables; nonzero starts a transfer
- h_compl  out  1  one-cycle completion pulse
- inv  in  1  invalidates the read buffer
- t_addr  out  32  word address {h_addr[31:2],2'b00}
- t_wdata  out  32  {h_wdata,h_wdata}
- t_rdata  in  32  target read data, sampled when t_compl=1
- t_wr_en  out  1  target write strobe
- t_bytesel  out  4  target byte enables; nonzero means a request is active
- t_compl  in  1  target completion pulse

## Operation
- Host protocol: the host holds its request (addr, wdata, wr_en, bytesel) stable until it sees h_compl. The bridge ignores h_bytesel in the h_compl cycle.
- States: IDLE, HIT, TGT, COMPL.
- IDLE, h_bytesel != 0:
  - Read that hits (buf_valid, buf_addr == h_addr[31:2], BUF_EN, inv=0): go to HIT.
  - Anything else: go to TGT.
- HIT: drive h_rdata = h_addr[1] ? buf[31:16] : buf[15:0] and pulse h_compl. Then go to IDLE.
- TGT: t_bytesel is nonzero until t_compl is sampled. Then go to COMPL.
  - Read: t_bytesel = 4'b1111. On t_compl, load buf = t_rdata, buf_addr = h_addr[31:2], buf_valid = 1, and register the selected halfword into h_rdata.
  - Write: t_bytesel = h_addr[1] ? {h_bytesel,2'b00} : {2'b00,h_bytesel}, and t_wr_en = 1. On t_compl, if the buffer holds the same word, merge the enabled bytes into buf; h_rdata is unchanged.
- COMPL: h_compl = 1 for one cycle, then go to IDLE.
- All host and target outputs are registered.
- Byte enables select byte lanes only. Bytes with enable 0 are not written to buf.
- inv:
  - Clears buf_valid the following cycle.
  - If inv is asserted in the same cycle as a hit decision, inv wins and the access is a miss.
  - If inv is asserted in the same cycle as a read t_compl, the fill still happens and then buf_valid is cleared. Result: invalid.
- Reset values:
  - state = IDLE, h_compl = 0, h_rdata = 0
  - t_bytesel = 0, t_wr_en = 0, t_addr = 0, t_wdata = 0
  - buf_valid = 0
- Reset during TGT abandons the target request: t_bytesel = 0 from the next cycle, and no h_compl is issued.

## Timing
- Read hit: request sampled in IDLE at cycle 0; h_compl and h_rdata valid at cycle 1. Latency 1.
- Miss or write: t_bytesel asserted at cycle 1. If t_compl is sampled at cycle k, t_bytesel = 0 at k+1 and h_compl = 1 at k+1. Minimum latency is 2 (t_compl at cycle 1).
- A new request may be sampled in the cycle after h_compl. Back-to-back hits give 1 completion every 2 cycles.
- t_compl is ignored outside TGT.
- t_addr, t_wdata and t_wr_en are stable for the whole TGT period.

## Structure
- Shared package bridge_pkg:
  - state encodings: IDLE=2'b00, HIT=2'b01, TGT=2'b11, COMPL=2'b10
  - halfword lane select helper
- Sub-module hword_buf: the 32-bit buffer with valid bit, tag compare, byte-merge write and invalidate. All other logic lives in the top-level FSM.

## Test plan
- Cold read at 0x100, t_rdata=0xCAFEBABE, t_compl at cycle 3 -> t_bytesel=4'hF during cycles 1-3; h_compl at cycle 4; h_rdata=0xBABE.
- Then read 0x102 -> no target access; h_compl at cycle 1; h_rdata=0xCAFE.
- Write 0x102, data 0x1234, bytesel 2'b10 -> t_bytesel=4'b1000, t_wdata=0x12341234. A following read of 0x102 hits with h_rdata=0x12FE.
- inv asserted in the same cycle as a read of 0x100 -> treated as a miss; a target access occurs.
- Read of 0x204 after the buffer holds 0x100 -> miss; buffer replaced. A following read of 0x100 also misses.
- rst asserted while in TGT, before t_compl -> t_bytesel=0 next cycle, no h_compl, buf_valid=0.
